// File: rtl/clock_monitor.sv
// -----------------------------------------------------------------------------
// clock_monitor
//
// Receive-side checker for a divided slow clock. The asynchronous slow clock is
// synchronized into the clk_i domain, its edges are detected, and the
// rising-edge-to-rising-edge period is measured in clk_i cycles. Each period is
// compared against EXP_PERIOD +/- TOL to drive lock, timeout and error status.
//
// Ports
//   clk_i          : system clock, all logic on its rising edge
//   reset_n        : asynchronous active-low reset
//   slow_clk_i     : monitored slow clock, asynchronous to clk_i
//   rise_o         : one-cycle pulse per detected rising edge
//   fall_o         : one-cycle pulse per detected falling edge
//   period_o       : last measured period (held between updates)
//   period_valid_o : one-cycle pulse when period_o updates
//   locked_o       : LOCK_N consecutive in-tolerance periods seen
//   timeout_o      : no rising edge within TIMEOUT_CYC cycles
//   err_cnt_o      : out-of-tolerance / timeout count, saturates at 255
// -----------------------------------------------------------------------------
module clock_monitor #(
    parameter int CNT_W       = 23,
    parameter int EXP_PERIOD  = 2080000,
    parameter int TOL         = 16,
    parameter int LOCK_N      = 4,
    parameter int TIMEOUT_CYC = 4194303
) (
    input  logic             clk_i,
    input  logic             reset_n,
    input  logic             slow_clk_i,
    output logic             rise_o,
    output logic             fall_o,
    output logic [CNT_W-1:0] period_o,
    output logic             period_valid_o,
    output logic             locked_o,
    output logic             timeout_o,
    output logic [7:0]       err_cnt_o
);

    typedef enum logic [1:0] {
        ACQUIRE = 2'b00,
        MEASURE = 2'b01
    } state_t;

    localparam logic [CNT_W-1:0] EXP_C     = CNT_W'(EXP_PERIOD);
    localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
    localparam logic [3:0]       LOCK_C    = 4'(LOCK_N);

    logic             sync1_q, sync2_q, dly_q;
    logic             rise, fall;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, diff;
    logic [CNT_W-1:0] period_d;
    logic [3:0]       lock_q, lock_d;
    logic [7:0]       err_d, err_inc;
    logic             pv_d, locked_d, timeout_d;
    logic             cnt_max, in_tol;

    // Two-flop synchronizer followed by the edge-detect delay flop.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would
    // collapse the synchronizer chain into a single stage.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
        end else begin
            sync1_q <= slow_clk_i;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    assign rise = sync2_q & ~dly_q;
    assign fall = ~sync2_q & dly_q;

    // Shared datapath terms.
    always_comb begin
        cnt_max = (cnt_q == TIMEOUT_C);
        cnt_inc = cnt_max ? cnt_q : cnt_q + ONE_C;
        // Larger minus smaller keeps the deviation unsigned with no wrap.
        diff    = (cnt_q >= EXP_C) ? (cnt_q - EXP_C) : (EXP_C - cnt_q);
        in_tol  = (diff <= TOL_C);
        err_inc = (err_cnt_o == 8'hFF) ? err_cnt_o : err_cnt_o + 8'd1;
    end

    // Next-state and next-output logic.
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_inc;
        period_d  = period_o;
        pv_d      = 1'b0;
        locked_d  = locked_o;
        timeout_d = timeout_o;
        err_d     = err_cnt_o;
        lock_d    = lock_q;

        case (state_q)
            ACQUIRE: begin
                if (rise) begin
                    // First edge only starts the measurement; nothing reported.
                    cnt_d     = ONE_C;
                    state_d   = MEASURE;
                    timeout_d = 1'b0;
                end else if (cnt_max) begin
                    timeout_d = 1'b1;
                end
            end
            MEASURE: begin
                // A rise takes priority over a coincident timeout.
                if (rise) begin
                    cnt_d    = ONE_C;
                    period_d = cnt_q;
                    pv_d     = 1'b1;
                    if (in_tol) begin
                        if (lock_q < LOCK_C) begin
                            lock_d = lock_q + 4'd1;
                        end
                        locked_d = (lock_d == LOCK_C);
                    end else begin
                        lock_d   = 4'd0;
                        locked_d = 1'b0;
                        err_d    = err_inc;
                    end
                end else if (cnt_max) begin
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                    lock_d    = 4'd0;
                    err_d     = err_inc;
                    state_d   = ACQUIRE;
                    cnt_d     = '0;
                end
            end
            default: begin
                // Illegal encoding: restart acquisition cleanly.
                state_d  = ACQUIRE;
                cnt_d    = '0;
                lock_d   = 4'd0;
                locked_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ACQUIRE;
            cnt_q          <= '0;
            lock_q         <= 4'd0;
            rise_o         <= 1'b0;
            fall_o         <= 1'b0;
            period_o       <= '0;
            period_valid_o <= 1'b0;
            locked_o       <= 1'b0;
            timeout_o      <= 1'b0;
            err_cnt_o      <= 8'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            lock_q         <= lock_d;
            rise_o         <= rise;
            fall_o         <= fall;
            period_o       <= period_d;
            period_valid_o <= pv_d;
            locked_o       <= locked_d;
            timeout_o      <= timeout_d;
            err_cnt_o      <= err_d;
        end
    end

endmodule

// File: tb/tb_clock_monitor.sv
// -----------------------------------------------------------------------------
// tb_clock_monitor
//
// Drives clock_monitor with a slow clock built from queued high/low segments
// (changes land on clk_i falling edges) and checks every cycle against an
// event-level reference model: an edge driven after rising edge n appears on
// rise_o/fall_o at rising edge n+3, and period/lock/timeout/error status is
// derived from the cycle numbers of those rises.
// -----------------------------------------------------------------------------
module tb_clock_monitor;

    localparam int CW   = 23;
    localparam int EXP  = 100;
    localparam int TOLB = 2;
    localparam int LOCK = 4;
    localparam int TMO  = 400;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          slow = 1'b0;
    logic          rise_o, fall_o, period_valid_o, locked_o, timeout_o;
    logic [CW-1:0] period_o;
    logic [7:0]    err_cnt_o;

    clock_monitor #(
        .CNT_W(CW), .EXP_PERIOD(EXP), .TOL(TOLB), .LOCK_N(LOCK), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk_i(clk), .reset_n(reset_n), .slow_clk_i(slow),
        .rise_o(rise_o), .fall_o(fall_o), .period_o(period_o),
        .period_valid_o(period_valid_o), .locked_o(locked_o),
        .timeout_o(timeout_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // ---------------- slow clock generator ----------------
    typedef struct { bit lvl; int dur; int tag; } seg_t;
    typedef struct { int at; bit is_rise; } ev_t;
    seg_t segq[$];
    ev_t  evq[$];
    int   hold = 0;
    int   rise_tag = 0;

    task automatic push_pair(input int per, input int hi, input int tag);
        segq.push_back('{1'b1, hi, tag});
        segq.push_back('{1'b0, per - hi, 0});
    endtask

    always @(negedge clk) begin
        seg_t s;
        if (hold > 0) hold--;
        if (hold == 0 && segq.size() > 0) begin
            s = segq.pop_front();
            if (s.lvl != slow) begin
                slow = s.lvl;
                if (reset_n) evq.push_back('{cyc + 3, s.lvl});
            end
            if (s.lvl) rise_tag = s.tag;
            hold = s.dur;
        end
    end

    // ---------------- reference model ----------------
    bit          exp_rise, exp_fall, exp_pv, exp_locked, exp_timeout;
    logic [7:0]  exp_err = 8'd0;
    logic [22:0] exp_period = '0;
    bit          measuring = 0;
    int          last_rise = 0;
    int          acq_base = 0;
    int          lock_run = 0;

    always @(posedge clk) begin
        int p, dev;
        bit r, f;
        cyc++;
        #1;
        r = 0;
        f = 0;
        exp_pv = 0;
        if (!reset_n) begin
            evq.delete();
            measuring   = 0;
            lock_run    = 0;
            exp_locked  = 0;
            exp_timeout = 0;
            exp_err     = 8'd0;
            exp_period  = '0;
            acq_base    = cyc;
        end else begin
            if (evq.size() > 0 && evq[0].at == cyc) begin
                if (evq[0].is_rise) r = 1; else f = 1;
                void'(evq.pop_front());
            end
            if (measuring) begin
                if (r) begin
                    p = cyc - last_rise;
                    exp_period = 23'(p);
                    exp_pv = 1;
                    dev = (p > EXP) ? p - EXP : EXP - p;
                    if (dev <= TOLB) begin
                        if (lock_run < LOCK) lock_run++;
                        exp_locked = (lock_run == LOCK);
                    end else begin
                        lock_run = 0;
                        exp_locked = 0;
                        if (exp_err < 8'd255) exp_err = exp_err + 8'd1;
                    end
                    last_rise = cyc;
                end else if (cyc - last_rise == TMO) begin
                    exp_timeout = 1;
                    exp_locked  = 0;
                    lock_run    = 0;
                    if (exp_err < 8'd255) exp_err = exp_err + 8'd1;
                    measuring   = 0;
                    acq_base    = cyc;
                end
            end else begin
                if (r) begin
                    measuring   = 1;
                    last_rise   = cyc;
                    exp_timeout = 0;
                end else if (cyc - acq_base > TMO) begin
                    exp_timeout = 1;
                end
            end
        end
        exp_rise = r;
        exp_fall = f;
    end

    function automatic logic [35:0] obs_vec();
        return {rise_o, fall_o, period_valid_o, locked_o, timeout_o, err_cnt_o, period_o};
    endfunction

    function automatic logic [35:0] exp_vec();
        return {exp_rise, exp_fall, exp_pv, exp_locked, exp_timeout, exp_err, exp_period};
    endfunction

    // Async reset pulse asserted between clock edges; release lands between edges too.
    task automatic pulse_reset(input int cycles);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({rise_o, fall_o, period_valid_o, locked_o, timeout_o, err_cnt_o, period_o} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_async_clear got %h want 0", obs_vec());
        end
        repeat (cycles) @(posedge clk);
        #2 reset_n = 1'b1;
        if (slow) evq.push_back('{cyc + 3, 1'b1});
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (rise_o !== 1'b0)         begin n_fail++; $display("FAIL reset_rise got %b want 0", rise_o); end
        n_cmp++; if (fall_o !== 1'b0)         begin n_fail++; $display("FAIL reset_fall got %b want 0", fall_o); end
        n_cmp++; if (period_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_pv got %b want 0", period_valid_o); end
        n_cmp++; if (locked_o !== 1'b0)       begin n_fail++; $display("FAIL reset_locked got %b want 0", locked_o); end
        n_cmp++; if (timeout_o !== 1'b0)      begin n_fail++; $display("FAIL reset_timeout got %b want 0", timeout_o); end
        n_cmp++; if (err_cnt_o !== 8'd0)      begin n_fail++; $display("FAIL reset_err got %0d want 0", err_cnt_o); end
        n_cmp++; if (period_o !== '0)         begin n_fail++; $display("FAIL reset_period got %0d want 0", period_o); end
        @(posedge clk);
        #2 reset_n = 1'b1;
    endtask

    task automatic test_nominal;
        int pvs = 0;
        for (int i = 0; i < 7; i++) push_pair(EXP, int'($urandom_range(80, 20)), 0);
        for (int i = 0; i < 7 * EXP + 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL nominal cyc=%0d got %h want %h", cyc, obs_vec(), exp_vec());
            end
            if (period_valid_o) pvs++;
        end
        n_cmp++; if (pvs != 6)            begin n_fail++; $display("FAIL nominal_pv_count got %0d want 6", pvs); end
        n_cmp++; if (locked_o !== 1'b1)   begin n_fail++; $display("FAIL nominal_locked got %b want 1", locked_o); end
        n_cmp++; if (err_cnt_o !== 8'd0)  begin n_fail++; $display("FAIL nominal_err got %0d want 0", err_cnt_o); end
        n_cmp++; if (period_o !== 23'd100) begin n_fail++; $display("FAIL nominal_period got %0d want 100", period_o); end
    endtask

    task automatic test_tolerance;
        int per[18];
        int tags[18];
        int total = 0;
        logic [7:0] err_before = 8'd0;
        for (int i = 0; i < 18; i++) begin
            per[i] = EXP;
            tags[i] = 0;
        end
        per[5] = 102;
        per[6] = 103;
        tags[6] = 1;   // this rise reports 102
        tags[7] = 2;   // this rise reports 103
        tags[10] = 4;  // third good period after 103
        tags[11] = 3;  // fourth good period after 103
        for (int i = 12; i < 18; i++) per[i] = int'($urandom_range(105, 95));
        for (int i = 0; i < 18; i++) begin
            push_pair(per[i], int'($urandom_range(80, 20)), tags[i]);
            total += per[i];
        end
        for (int i = 0; i < total + 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL tolerance cyc=%0d got %h want %h", cyc, obs_vec(), exp_vec());
            end
            if (period_valid_o && rise_tag == 1) begin
                err_before = exp_err;
                n_cmp++;
                if (locked_o !== 1'b1 || period_o !== 23'd102) begin
                    n_fail++;
                    $display("FAIL tol_102_keeps_lock got locked=%b period=%0d want 1/102", locked_o, period_o);
                end
            end
            if (period_valid_o && rise_tag == 2) begin
                n_cmp++;
                if (locked_o !== 1'b0 || err_cnt_o !== err_before + 8'd1) begin
                    n_fail++;
                    $display("FAIL tol_103_drops got locked=%b err=%0d want 0/%0d", locked_o, err_cnt_o, err_before + 8'd1);
                end
            end
            if (period_valid_o && rise_tag == 4) begin
                n_cmp++;
                if (locked_o !== 1'b0) begin n_fail++; $display("FAIL tol_relock_early got %b want 0", locked_o); end
            end
            if (period_valid_o && rise_tag == 3) begin
                n_cmp++;
                if (locked_o !== 1'b1) begin n_fail++; $display("FAIL tol_relock got %b want 1", locked_o); end
            end
        end
    endtask

    task automatic test_timeout;
        int t_rise = -1;
        bit seen_to = 0;
        int pvs = 0;
        logic [7:0] err_mark = 8'd0;
        for (int i = 0; i < 6; i++) push_pair(EXP, int'($urandom_range(80, 20)), (i == 5) ? 5 : 0);
        for (int i = 0; i < 6 * EXP + TMO + 60; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL timeout cyc=%0d got %h want %h", cyc, obs_vec(), exp_vec());
            end
            if (period_valid_o && rise_tag == 5 && t_rise < 0) begin
                t_rise = cyc;
                err_mark = exp_err;
                n_cmp++;
                if (locked_o !== 1'b1) begin n_fail++; $display("FAIL timeout_pre_locked got %b want 1", locked_o); end
            end
            if (timeout_o && !seen_to && t_rise >= 0) begin
                seen_to = 1;
                n_cmp++;
                if (cyc - t_rise != TMO) begin
                    n_fail++;
                    $display("FAIL timeout_latency got %0d want %0d", cyc - t_rise, TMO);
                end
            end
        end
        n_cmp++; if (timeout_o !== 1'b1) begin n_fail++; $display("FAIL timeout_flag got %b want 1", timeout_o); end
        n_cmp++; if (locked_o !== 1'b0)  begin n_fail++; $display("FAIL timeout_unlock got %b want 0", locked_o); end
        n_cmp++; if (err_cnt_o !== err_mark + 8'd1) begin
            n_fail++; $display("FAIL timeout_err got %0d want %0d", err_cnt_o, err_mark + 8'd1);
        end
        // Restart: first rise clears timeout, only the second reports a period.
        for (int i = 0; i < 3; i++) push_pair(EXP, int'($urandom_range(80, 20)), 0);
        for (int i = 0; i < 3 * EXP + 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL restart cyc=%0d got %h want %h", cyc, obs_vec(), exp_vec());
            end
            if (period_valid_o) pvs++;
        end
        n_cmp++; if (pvs != 2)           begin n_fail++; $display("FAIL restart_pv_count got %0d want 2", pvs); end
        n_cmp++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL restart_timeout got %b want 0", timeout_o); end
    endtask

    task automatic test_edges;
        int total = 0;
        int rises = 0;
        int falls = 0;
        int hi, lo;
        for (int i = 0; i < 20; i++) begin
            hi = int'($urandom_range(6, 2));
            lo = int'($urandom_range(6, 2));
            push_pair(hi + lo, hi, 0);
            total += hi + lo;
        end
        for (int i = 0; i < total + 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL edges cyc=%0d got %h want %h", cyc, obs_vec(), exp_vec());
            end
            if (rise_o) rises++;
            if (fall_o) falls++;
        end
        n_cmp++; if (rises != 20) begin n_fail++; $display("FAIL edges_rise_count got %0d want 20", rises); end
        n_cmp++; if (falls != 20) begin n_fail++; $display("FAIL edges_fall_count got %0d want 20", falls); end
    endtask

    task automatic test_reset_mid;
        int rises = 0;
        int pvs = 0;
        for (int i = 0; i < 9; i++) push_pair(EXP, 50, 0);
        for (int i = 0; i < 637; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_mid_pre cyc=%0d got %h want %h", cyc, obs_vec(), exp_vec());
            end
        end
        n_cmp++; if (locked_o !== 1'b1) begin n_fail++; $display("FAIL reset_mid_locked got %b want 1", locked_o); end
        pulse_reset(5);
        for (int i = 0; i < 280; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_mid_post cyc=%0d got %h want %h", cyc, obs_vec(), exp_vec());
            end
            if (rise_o) rises++;
            if (period_valid_o) pvs++;
        end
        n_cmp++;
        if (rises < 2 || pvs != rises - 1) begin
            n_fail++;
            $display("FAIL reset_mid_first_period got rises=%0d pvs=%0d want pvs=rises-1", rises, pvs);
        end
    endtask

    task automatic test_held_high;
        int rises = 0;
        segq.push_back('{1'b1, 5, 0});
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL held_pre cyc=%0d got %h want %h", cyc, obs_vec(), exp_vec());
            end
        end
        pulse_reset(4);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL held_post cyc=%0d got %h want %h", cyc, obs_vec(), exp_vec());
            end
            if (rise_o) rises++;
        end
        n_cmp++; if (rises != 1) begin n_fail++; $display("FAIL held_single_rise got %0d want 1", rises); end
    endtask

    task automatic test_err_saturation;
        int locked_seen = 0;
        for (int i = 0; i < 300; i++) push_pair(50, 25, 0);
        for (int i = 0; i < 300 * 50 + 20; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL saturation cyc=%0d got %h want %h", cyc, obs_vec(), exp_vec());
            end
            if (locked_o) locked_seen++;
        end
        n_cmp++; if (err_cnt_o !== 8'd255) begin n_fail++; $display("FAIL sat_err got %0d want 255", err_cnt_o); end
        n_cmp++; if (locked_seen != 0)    begin n_fail++; $display("FAIL sat_locked got %0d locked cycles want 0", locked_seen); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_nominal();
        test_tolerance();
        test_timeout();
        test_edges();
        test_reset_mid();
        test_held_high();
        test_err_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
